// File: rtl/polyphase_fir_interp.sv
// ---------------------------------------------------------------------------
// polyphase_fir_interp
//   Polyphase interpolating FIR for the TX path (symbol mapper -> channel
//   model). Each accepted symbol produces N_OS output samples, one per phase,
//   computed as y[p] = sum_k x[k] * h[k*N_OS + p] with x[0] the newest symbol.
//   Coefficients live in a runtime-writable bank spread across the taps.
//   Pipeline: stage 1 registers the per-tap products, stage 2 registers the
//   rounded (half up) and saturated sum. Fixed latency of 2 clocks.
//
// Ports
//   clk           clock
//   i_rst_n       asynchronous active-low reset
//   i_data        input symbol S(NB_INPUT,NBF_INPUT)
//   i_valid       i_data valid
//   o_ready       a symbol can be accepted this cycle (combinational)
//   i_coeff_we    coefficient write strobe
//   i_coeff_addr  coefficient index h[addr]; addr >= N_BAUD*N_OS is ignored
//   i_coeff_data  coefficient value S(NB_COEFF,NBF_COEFF)
//   o_data        output sample S(NB_OUTPUT,NBF_OUTPUT)
//   o_valid       o_data valid
//   o_phase       phase index of o_data
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// polyphase_fir_tap
//   One filter tap: holds the N_OS coefficients h[TAP*N_OS + p] for this
//   symbol position, selects the one for the current phase and registers the
//   signed product with its symbol (pipeline stage 1).
//
// Ports
//   clk, i_rst_n   clock, asynchronous active-low reset
//   i_x            symbol held at this tap position
//   i_phase        current phase
//   i_coeff_*      shared coefficient write port
//   o_prod         registered product, NB_INPUT+NB_COEFF bits
// ---------------------------------------------------------------------------
module polyphase_fir_tap #(
    parameter int NB_INPUT = 8,
    parameter int NB_COEFF = 8,
    parameter int N_OS     = 4,
    parameter int NB_PHASE = 2,
    parameter int NB_ADDR  = 5,
    parameter int TAP      = 0
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic [NB_INPUT-1:0]          i_x,
    input  logic [NB_PHASE-1:0]          i_phase,
    input  logic                         i_coeff_we,
    input  logic [NB_ADDR-1:0]           i_coeff_addr,
    input  logic [NB_COEFF-1:0]          i_coeff_data,
    output logic [NB_INPUT+NB_COEFF-1:0] o_prod
);
    localparam int NB_PROD = NB_INPUT + NB_COEFF;

    logic [N_OS-1:0][NB_COEFF-1:0] coef_w;
    logic [NB_PROD-1:0]            x_ext;
    logic [NB_PROD-1:0]            c_ext;
    logic [NB_PROD-1:0]            prod_d;
    logic [NB_PROD-1:0]            prod_q;

    // Each coefficient register decodes its own global address, so any
    // address outside the bank simply matches no register.
    genvar p;
    for (p = 0; p < N_OS; p++) begin : g_ph
        localparam logic [NB_ADDR-1:0] ADDR = NB_ADDR'(TAP*N_OS + p);
        logic [NB_COEFF-1:0] h_q;

        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n)
                h_q <= '0;
            else if (i_coeff_we && (i_coeff_addr == ADDR))
                h_q <= i_coeff_data;
        end

        assign coef_w[p] = h_q;
    end

    // Operands are sign-extended to the full product width so the low
    // NB_PROD bits of the multiply are the exact signed product.
    assign x_ext  = {{NB_COEFF{i_x[NB_INPUT-1]}}, i_x};
    assign c_ext  = {{NB_INPUT{coef_w[i_phase][NB_COEFF-1]}}, coef_w[i_phase]};
    assign prod_d = $signed(x_ext) * $signed(c_ext);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            prod_q <= '0;
        else
            prod_q <= prod_d;
    end

    assign o_prod = prod_q;

endmodule

module polyphase_fir_interp #(
    parameter int NB_INPUT   = 8,
    parameter int NBF_INPUT  = 7,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 7,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 7,
    parameter int N_BAUD     = 6,
    parameter int N_OS       = 4,
    parameter int NB_PHASE   = 2,
    parameter int NB_ADDR    = 5
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic [NB_INPUT-1:0]  i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_coeff_we,
    input  logic [NB_ADDR-1:0]   i_coeff_addr,
    input  logic [NB_COEFF-1:0]  i_coeff_data,
    output logic [NB_OUTPUT-1:0] o_data,
    output logic                 o_valid,
    output logic [NB_PHASE-1:0]  o_phase
);
    localparam int NB_PROD = NB_INPUT + NB_COEFF;
    localparam int NB_SUM  = NB_PROD + $clog2(N_BAUD);
    // One extra bit so adding the rounding constant cannot wrap.
    localparam int NB_RND  = NB_SUM + 1;
    localparam int SHIFT   = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;
    localparam int STAGES  = 2;

    localparam logic [NB_PHASE-1:0]      PH_LAST  = NB_PHASE'(N_OS - 1);
    localparam logic [NB_PHASE-1:0]      PH_ONE   = NB_PHASE'(1);
    localparam logic [NB_RND-1:0]        RND_HALF = NB_RND'(1) << (SHIFT - 1);
    localparam logic signed [NB_RND-1:0] SAT_MAX  =
        {{(NB_RND-NB_OUTPUT+1){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
    localparam logic signed [NB_RND-1:0] SAT_MIN  =
        {{(NB_RND-NB_OUTPUT+1){1'b1}}, {(NB_OUTPUT-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                            state_q, state_d;
    logic [NB_PHASE-1:0]               phase_q, phase_d;
    logic                              ready_w;
    logic                              run_w;
    logic                              accept_w;

    logic [N_BAUD-1:0][NB_INPUT-1:0]   x_q;
    logic [N_BAUD-1:0][NB_PROD-1:0]    prod_w;
    logic [N_BAUD:0][NB_SUM-1:0]       psum_w;
    logic [NB_RND-1:0]                 rnd_w;
    logic signed [NB_RND-1:0]          shr_w;
    logic [NB_OUTPUT-1:0]              data_d;

    logic [NB_OUTPUT-1:0]              o_data_q;
    logic [STAGES:1]                   vld_pipe_q;
    logic [STAGES:1][NB_PHASE-1:0]     ph_pipe_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // A symbol can only arrive in IDLE or on the last phase of RUN, so an
    // accept always restarts the phase count at 0.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (accept_w) begin
                    phase_d = '0;
                end else if (phase_q == PH_LAST) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        ready_w = 1'b0;
        run_w   = 1'b0;
        case (state_q)
            IDLE:    ready_w = 1'b1;
            RUN: begin
                run_w   = 1'b1;
                ready_w = (phase_q == PH_LAST);
            end
            default: ready_w = 1'b0;
        endcase
    end

    assign accept_w = i_valid & ready_w;
    assign o_ready  = ready_w;

    // ------------------------------------------------------ symbol history
    // History is kept across IDLE on purpose: old symbols keep contributing
    // when streaming resumes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            x_q <= '0;
        else if (accept_w)
            x_q <= {x_q[N_BAUD-2:0], i_data};
    end

    // ------------------------------------------------ taps (pipe stage 1)
    genvar k;
    for (k = 0; k < N_BAUD; k++) begin : g_tap
        polyphase_fir_tap #(
            .NB_INPUT (NB_INPUT),
            .NB_COEFF (NB_COEFF),
            .N_OS     (N_OS),
            .NB_PHASE (NB_PHASE),
            .NB_ADDR  (NB_ADDR),
            .TAP      (k)
        ) u_tap (
            .clk          (clk),
            .i_rst_n      (i_rst_n),
            .i_x          (x_q[k]),
            .i_phase      (phase_q),
            .i_coeff_we   (i_coeff_we),
            .i_coeff_addr (i_coeff_addr),
            .i_coeff_data (i_coeff_data),
            .o_prod       (prod_w[k])
        );

        assign psum_w[k+1] = psum_w[k] +
            {{(NB_SUM-NB_PROD){prod_w[k][NB_PROD-1]}}, prod_w[k]};
    end

    assign psum_w[0] = '0;

    // ------------------------------------------ round / saturate (stage 2)
    assign rnd_w = {psum_w[N_BAUD][NB_SUM-1], psum_w[N_BAUD]} + RND_HALF;
    assign shr_w = $signed(rnd_w) >>> SHIFT;

    always_comb begin
        if (shr_w > SAT_MAX)
            data_d = SAT_MAX[NB_OUTPUT-1:0];
        else if (shr_w < SAT_MIN)
            data_d = SAT_MIN[NB_OUTPUT-1:0];
        else
            data_d = shr_w[NB_OUTPUT-1:0];
    end

    // Valid and phase travel alongside the data through both stages.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_q   <= '0;
            vld_pipe_q <= '0;
            ph_pipe_q  <= '0;
        end else begin
            o_data_q   <= data_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], run_w};
            ph_pipe_q  <= {ph_pipe_q[STAGES-1:1], phase_q};
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = vld_pipe_q[STAGES];
    assign o_phase = ph_pipe_q[STAGES];

endmodule

// File: tb/tb_polyphase_fir_interp.sv
// ---------------------------------------------------------------------------
// tb_polyphase_fir_interp
//   Directed bench for polyphase_fir_interp with default parameters.
//   Cycle tables cover the impulse response and a live coefficient write;
//   hand-written sequences cover reset, gaps, back-pressure and saturation.
// ---------------------------------------------------------------------------
module tb_polyphase_fir_interp;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_coeff_we;
    logic [4:0] i_coeff_addr;
    logic [7:0] i_coeff_data;
    logic [7:0] o_data;
    logic       o_valid;
    logic [1:0] o_phase;

    always #5 clk = ~clk;

    polyphase_fir_interp #(
        .NB_INPUT(8), .NBF_INPUT(7), .NB_COEFF(8), .NBF_COEFF(7),
        .NB_OUTPUT(8), .NBF_OUTPUT(7), .N_BAUD(6), .N_OS(4),
        .NB_PHASE(2), .NB_ADDR(5)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_coeff_we   (i_coeff_we),
        .i_coeff_addr (i_coeff_addr),
        .i_coeff_data (i_coeff_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_phase      (o_phase)
    );

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       erdy;
        logic       evld;
        logic [7:0] edata;
        logic [1:0] eph;
    } vec_t;

    vec_t       tab[12];
    int         n_pass = 0;
    int         n_tot  = 0;
    logic [7:0] outq[$];
    logic [7:0] syms[16];
    logic       prev_v;
    int         rises;
    int         badgap;
    int         acc;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic vec_t mkv(logic vin, logic [7:0] din, logic erdy,
                                 logic evld, logic [7:0] edata, logic [1:0] eph);
        vec_t v;
        v.vin = vin;   v.din = din;
        v.we = 1'b0;   v.wa = 5'd0;   v.wd = 8'd0;
        v.erdy = erdy; v.evld = evld; v.edata = edata; v.eph = eph;
        return v;
    endfunction

    task automatic wr(input int a, input int d);
        i_coeff_we   = 1'b1;
        i_coeff_addr = a[4:0];
        i_coeff_data = d[7:0];
        @(posedge clk); #1;
        i_coeff_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_coeff_we = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        i_rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_tab(input string tag);
        for (int i = 0; i < 12; i++) begin
            i_valid      = tab[i].vin;
            i_data       = tab[i].din;
            i_coeff_we   = tab[i].we;
            i_coeff_addr = tab[i].wa;
            i_coeff_data = tab[i].wd;
            #1;
            chk($sformatf("%s[%0d].ready", tag, i), int'(o_ready), int'(tab[i].erdy));
            chk($sformatf("%s[%0d].valid", tag, i), int'(o_valid), int'(tab[i].evld));
            if (tab[i].evld) begin
                chk($sformatf("%s[%0d].data", tag, i), int'(o_data), int'(tab[i].edata));
                chk($sformatf("%s[%0d].phase", tag, i), int'(o_phase), int'(tab[i].eph));
            end
            @(posedge clk); #1;
        end
        i_valid    = 1'b0;
        i_coeff_we = 1'b0;
    endtask

    task automatic sample();
        if (o_valid) begin
            outq.push_back(o_data);
            if (!prev_v) rises++;
        end
        prev_v = o_valid;
    endtask

    // Offers syms[0..n-1] with i_valid held high, advancing only on accept.
    task automatic stream(input int n);
        int cyc;
        int last;
        outq.delete();
        prev_v = 1'b0; rises = 0; badgap = 0; acc = 0;
        cyc = 0; last = -1;
        i_valid = 1'b1;
        i_data  = syms[0];
        while (acc < n && cyc < 200) begin
            sample();
            if (o_ready) begin
                if (last >= 0 && cyc - last != 4) badgap++;
                last = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc < n) i_data = syms[acc];
            else         i_valid = 1'b0;
        end
        i_valid = 1'b0;
        repeat (10) begin
            sample();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nv;
        int nr;
        int nz;
        logic ok;

        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0;
        i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;

        // ---- reset state
        @(posedge clk); #1;
        chk("rst.valid", int'(o_valid), 0);
        chk("rst.data",  int'(o_data),  0);
        chk("rst.phase", int'(o_phase), 0);
        #3 i_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready", int'(o_ready), 1);

        // ---- impulse with h[i]=i; out-of-range writes must not land
        for (int i = 0; i < 24; i++) wr(i, i);
        for (int i = 24; i < 32; i++) wr(i, 8'h7F);

        tab[0]  = mkv(1'b1, 8'h40, 1'b1, 1'b0, 8'd0, 2'd0);
        tab[1]  = mkv(1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 2'd0);
        tab[2]  = mkv(1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 2'd0);
        tab[3]  = mkv(1'b1, 8'h00, 1'b0, 1'b1, 8'd0, 2'd0);
        tab[4]  = mkv(1'b1, 8'h00, 1'b1, 1'b1, 8'd1, 2'd1);
        tab[5]  = mkv(1'b0, 8'h00, 1'b0, 1'b1, 8'd1, 2'd2);
        tab[6]  = mkv(1'b0, 8'h00, 1'b0, 1'b1, 8'd2, 2'd3);
        tab[7]  = mkv(1'b0, 8'h00, 1'b0, 1'b1, 8'd2, 2'd0);
        tab[8]  = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'd3, 2'd1);
        tab[9]  = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'd3, 2'd2);
        tab[10] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 8'd4, 2'd3);
        tab[11] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 2'd0);
        run_tab("imp");

        // ---- reset in the middle of a run (phase 2, between edges)
        i_valid = 1'b1; i_data = 8'h7F;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // x = {7F, 00, 40, 0...}: phase 0 = 64*h[8] = 512 -> 4
        chk("mid.pre_valid", int'(o_valid), 1);
        chk("mid.pre_data",  int'(o_data),  4);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid.valid", int'(o_valid), 0);
        chk("mid.data",  int'(o_data),  0);
        chk("mid.phase", int'(o_phase), 0);
        @(posedge clk); #3 i_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid.ready", int'(o_ready), 1);
        i_valid = 1'b1; i_data = 8'h7F;
        @(posedge clk); #1;
        i_valid = 1'b0;
        nv = 0; nz = 0;
        repeat (8) begin
            if (o_valid) begin
                nv++;
                if (o_data != 8'h00) nz++;
            end
            @(posedge clk); #1;
        end
        chk("mid.post_nvalid", nv, 4);
        chk("mid.coeff_cleared", nz, 0);

        // ---- live write of h[5]=0 while the second symbol is in flight
        do_reset();
        for (int i = 0; i < 24; i++) wr(i, i);
        tab[5].we = 1'b1; tab[5].wa = 5'd5; tab[5].wd = 8'h00;
        tab[8].edata = 8'd0;
        run_tab("live");

        // ---- back-pressure: h[0..3]=0.5, symbol 2i+2 -> every phase i+1
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, 8'h40);
        for (int i = 0; i < 8; i++) syms[i] = 8'(2*i + 2);
        stream(8);
        chk("bp.accepts", acc, 8);
        chk("bp.gaps", badgap, 0);
        chk("bp.rises", rises, 1);
        chk("bp.count", outq.size(), 32);
        for (int i = 0; i < 8; i++) begin
            ok = (outq.size() == 32);
            if (ok)
                for (int p = 0; p < 4; p++)
                    if (outq[4*i + p] != 8'(i + 1)) ok = 1'b0;
            chk($sformatf("bp.sym%0d", i), int'(ok), 1);
        end

        // ---- gap: one symbol then i_valid low for 10 cycles
        #1;
        chk("gap.ready0", int'(o_ready), 1);
        i_valid = 1'b1; i_data = 8'h20;
        @(posedge clk); #1;
        i_valid = 1'b0;
        nv = 0; nr = 0; nz = 0;
        repeat (10) begin
            if (o_valid) begin
                nv++;
                if (o_data != 8'd16) nz++;
            end
            if (o_ready) nr++;
            @(posedge clk); #1;
        end
        chk("gap.nvalid", nv, 4);
        chk("gap.nready", nr, 7);
        chk("gap.data", nz, 0);
        chk("gap.idle_valid", int'(o_valid), 0);

        // ---- saturation: all h=0x7F, six 0x7F then six 0x80
        do_reset();
        for (int i = 0; i < 24; i++) wr(i, 8'h7F);
        for (int i = 0; i < 6; i++)  syms[i] = 8'h7F;
        for (int i = 6; i < 12; i++) syms[i] = 8'h80;
        stream(12);
        chk("sat.count", outq.size(), 48);
        chk("sat.rises", rises, 1);
        if (outq.size() == 48) begin
            chk("sat.first", int'(outq[0]), 126);
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("sat.pos%0d", p), int'(outq[20 + p]), 8'h7F);
                chk($sformatf("sat.neg%0d", p), int'(outq[44 + p]), 8'h80);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1);
    end

endmodule
